// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 hex keypad column scanner.
// Latency: combinational helpers only, no state.
// Backpressure: none; pure definitions.
package keypad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETTLE   = 3'd1,
    ST_SAMPLE   = 3'd2,
    ST_DEBOUNCE = 3'd3,
    ST_PRESSED  = 3'd4
  } state_t;

  // Rows are active-low; bit 3 is the top row (row0).
  localparam logic [3:0] ROW_NONE = 4'b1111;
  localparam logic [3:0] ROW_0    = 4'b0111;
  localparam logic [3:0] ROW_1    = 4'b1011;
  localparam logic [3:0] ROW_2    = 4'b1101;
  localparam logic [3:0] ROW_3    = 4'b1110;

  // Exactly one row low; multi-row patterns are treated as no key.
  function automatic logic row_valid(input logic [3:0] r);
    return (r == ROW_0) || (r == ROW_1) || (r == ROW_2) || (r == ROW_3);
  endfunction

  // Hex code of the key at (column, active row pattern).
  function automatic logic [3:0] key_code(input logic [1:0] c, input logic [3:0] r);
    logic [1:0] ri;
    logic [3:0] k;
    case (r)
      ROW_0:   ri = 2'd0;
      ROW_1:   ri = 2'd1;
      ROW_2:   ri = 2'd2;
      default: ri = 2'd3;
    endcase
    case ({c, ri})
      4'h0: k = 4'h1;  4'h1: k = 4'h4;  4'h2: k = 4'h7;  4'h3: k = 4'hA;
      4'h4: k = 4'h2;  4'h5: k = 4'h5;  4'h6: k = 4'h8;  4'h7: k = 4'h0;
      4'h8: k = 4'h3;  4'h9: k = 4'h6;  4'hA: k = 4'h9;  4'hB: k = 4'hB;
      4'hC: k = 4'hF;  4'hD: k = 4'hE;  4'hE: k = 4'hD;  default: k = 4'hC;
    endcase
    return k;
  endfunction

  // One-hot-low column drive for the selected column.
  function automatic logic [3:0] col_onehot_n(input logic [1:0] c);
    return ~(4'b0001 << c);
  endfunction

endpackage

// File: rtl/scan_counter.sv
// Shared settle/debounce counter with clear, load-one, increment and terminal compare.
// Latency: count updates on the next edge; hit_o is combinational from the count.
// Backpressure: none; controlled entirely by the owning FSM.
module scan_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             load1_i,
  input  logic             inc_i,
  input  logic [CNT_W-1:0] term_i,
  output logic             hit_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear wins over load-one, which wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load1_i) begin
      cnt_d = CNT_W'(1);
    end else if (inc_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = (cnt_q == term_i);

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Column-scan sequencer for a 4x4 hex keypad: settle, sample, debounce, report one event per press.
// Latency: key_valid in the 21st cycle after a column change (defaults) for a key already stable.
// Backpressure: none; scanning freezes while a key is held, enable low parks the block in IDLE.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int DEBOUNCE_CNT  = 4,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [3:0] row,
  output logic [1:0] col,
  output logic [3:0] col_drv_n,
  output logic [3:0] key_value,
  output logic       key_valid,
  output logic       key_held
);

  // The counter holds its terminal value in the last cycle of a phase, so compare against N-1.
  localparam logic [CNT_W-1:0] SETTLE_TERM = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_TERM    = CNT_W'(DEBOUNCE_CNT - 1);

  state_t     state_q, state_d;
  logic [1:0] col_q, col_d;
  logic [3:0] pat_q, pat_d;
  logic [3:0] val_q, val_d;
  logic       vld_q, vld_d;

  logic             cnt_clr, cnt_load1, cnt_inc, cnt_hit;
  logic [CNT_W-1:0] cnt_term;

  assign cnt_term = (state_q == ST_SETTLE) ? SETTLE_TERM : DEB_TERM;

  scan_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (cnt_clr),
    .load1_i (cnt_load1),
    .inc_i   (cnt_inc),
    .term_i  (cnt_term),
    .hit_o   (cnt_hit)
  );

  // Next-state, column, latch and counter control; enable low overrides every state.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    pat_d     = pat_q;
    val_d     = val_q;
    vld_d     = 1'b0;
    cnt_clr   = 1'b0;
    cnt_load1 = 1'b0;
    cnt_inc   = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SETTLE;
          cnt_clr = 1'b1;
        end
        ST_SETTLE: begin
          if (cnt_hit) state_d = ST_SAMPLE;
          else         cnt_inc = 1'b1;
        end
        ST_SAMPLE: begin
          if (row_valid(row)) begin
            pat_d     = row;
            cnt_load1 = 1'b1;
            state_d   = ST_DEBOUNCE;
          end else begin
            col_d   = col_q + 2'd1;
            cnt_clr = 1'b1;
            state_d = ST_SETTLE;
          end
        end
        ST_DEBOUNCE: begin
          if (row == pat_q) begin
            if (cnt_hit) begin
              state_d = ST_PRESSED;
              cnt_clr = 1'b1;
              val_d   = key_code(col_q, pat_q);
              vld_d   = 1'b1;
            end else begin
              cnt_inc = 1'b1;
            end
          end else begin
            col_d   = col_q + 2'd1;
            cnt_clr = 1'b1;
            state_d = ST_SETTLE;
          end
        end
        ST_PRESSED: begin
          if (row == ROW_NONE) begin
            if (cnt_hit) begin
              col_d   = col_q + 2'd1;
              cnt_clr = 1'b1;
              state_d = ST_SETTLE;
            end else begin
              cnt_inc = 1'b1;
            end
          end else begin
            cnt_clr = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_clr = 1'b1;
        end
      endcase
    end
  end

  // State, column and key registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      col_q   <= 2'd0;
      pat_q   <= ROW_NONE;
      val_q   <= 4'h0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      pat_q   <= pat_d;
      val_q   <= val_d;
      vld_q   <= vld_d;
    end
  end

  assign col       = col_q;
  assign col_drv_n = (state_q == ST_IDLE) ? ROW_NONE : col_onehot_n(col_q);
  assign key_value = val_q;
  assign key_valid = vld_q;
  assign key_held  = (state_q == ST_PRESSED);

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench for keypad_scan_ctrl: directed scenarios plus random key activity.
// Latency: every cycle's outputs are compared one time unit after the rising edge.
// Backpressure: not applicable.
module tb_keypad_scan_ctrl;

  localparam int S_CYC = 16;
  localparam int D_CNT = 4;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [3:0] row;
  logic [1:0] col;
  logic [3:0] col_drv_n;
  logic [3:0] key_value;
  logic       key_valid;
  logic       key_held;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  keypad_scan_ctrl #(.SETTLE_CYCLES(S_CYC), .DEBOUNCE_CNT(D_CNT), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .row       (row),
    .col       (col),
    .col_drv_n (col_drv_n),
    .key_value (key_value),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key map, indexed by column*4 + row index (row0 = top).
  logic [3:0] kmap [16] = '{4'h1, 4'h4, 4'h7, 4'hA,
                            4'h2, 4'h5, 4'h8, 4'h0,
                            4'h3, 4'h6, 4'h9, 4'hB,
                            4'hF, 4'hE, 4'hD, 4'hC};

  // Reference model: scanning described by age within a column and runs of equal samples.
  bit         m_active;
  bit         m_held;
  int         m_col;
  int         m_age;
  int         m_run;
  int         m_rel;
  logic [3:0] m_pat;
  logic [3:0] m_val;
  bit         m_vld;

  function automatic int row_index(input logic [3:0] r);
    for (int i = 0; i < 4; i++) if (r[3-i] == 1'b0) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_active = 0; m_held = 0; m_col = 0; m_age = 0; m_run = 0; m_rel = 0;
    m_pat = 4'hF; m_val = 4'h0; m_vld = 0;
  endtask

  task automatic model_next_col();
    m_col = (m_col + 1) % 4;
    m_age = 0;
    m_run = 0;
  endtask

  task automatic model_step(input logic en, input logic [3:0] r);
    m_vld = 0;
    if (!en) begin
      m_active = 0;
      m_held   = 0;
      return;
    end
    if (!m_active) begin
      m_active = 1;
      m_age    = 0;
      m_run    = 0;
      return;
    end
    if (m_held) begin
      m_rel = (r == 4'hF) ? m_rel + 1 : 0;
      if (m_rel == D_CNT) begin
        m_held = 0;
        model_next_col();
      end
      return;
    end
    if (m_age < S_CYC) begin
      m_age++;
      return;
    end
    if (m_run == 0) begin
      if ($countones(~r) == 1) begin
        m_pat = r;
        m_run = 1;
      end else begin
        model_next_col();
      end
    end else if (r == m_pat) begin
      m_run++;
      if (m_run == D_CNT) begin
        m_held = 1;
        m_rel  = 0;
        m_vld  = 1;
        m_val  = kmap[m_col*4 + row_index(m_pat)];
        m_run  = 0;
      end
    end else begin
      model_next_col();
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic check_all();
    logic [3:0] drv;
    logic [3:0] onehot;
    onehot = 4'b0001;
    drv = m_active ? ~(onehot << m_col) : 4'hF;
    check("col",       col,       m_col);
    check("col_drv_n", col_drv_n, drv);
    check("key_valid", key_valid, m_vld);
    check("key_held",  key_held,  m_held);
    check("key_value", key_value, m_val);
  endtask

  // Keypad pins: a pressed key pulls its row low only while its column is driven.
  function automatic logic [3:0] phys(input int kc, input int kr);
    logic [3:0] top;
    top = 4'b1000;
    return (col_drv_n[kc[1:0]] === 1'b0) ? ~(top >> kr) : 4'hF;
  endfunction

  task automatic cyc(input logic en, input logic [3:0] rv);
    enable = en;
    row    = rv;
    @(posedge clk);
    model_step(en, rv);
    #1;
    if (key_valid === 1'b1) pulses++;
    check_all();
  endtask

  // Run until the column changes to target; key (kc,kr) pressed when kon.
  task automatic wait_col(input logic [1:0] target, input bit kon, input int kc, input int kr);
    logic [1:0] prev;
    bit         hit;
    prev = col;
    hit  = 0;
    for (int n = 0; n < 300 && !hit; n++) begin
      cyc(1'b1, kon ? phys(kc, kr) : 4'hF);
      if (col === target && prev !== target) hit = 1;
      prev = col;
    end
    check("wait_col", hit, 1);
  endtask

  task automatic wait_held(input int kc, input int kr);
    for (int n = 0; n < 300 && key_held !== 1'b1; n++) cyc(1'b1, phys(kc, kr));
    check("wait_held", key_held, 1);
  endtask

  initial begin
    int hold_left;
    bit key_on;
    int kc, kr;
    logic [3:0] rv;
    logic en;

    // Reset values.
    rst_n  = 1'b0;
    enable = 1'b0;
    row    = 4'hF;
    model_reset();
    #1;
    check_all();
    #11 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'hF);

    // Free scan without keys: a column lasts 16 settle cycles plus one sample.
    cyc(1'b1, 4'hF);
    for (int i = 0; i < 16; i++) cyc(1'b1, 4'hF);
    check("scan_col0_last", col, 0);
    cyc(1'b1, 4'hF);
    check("scan_col1", col, 1);
    check("scan_drv1", col_drv_n, 4'b1101);
    for (int i = 0; i < 17; i++) cyc(1'b1, 4'hF);
    check("scan_col2", col, 2);
    check("scan_drv2", col_drv_n, 4'b1011);
    check("scan_no_pulse", pulses, 0);

    // Key 8 (col1, row2) held before col1 is selected.
    wait_col(2'd1, 1'b1, 1, 2);
    for (int i = 0; i < 19; i++) cyc(1'b1, phys(1, 2));
    check("press_c20_quiet", key_valid, 0);
    cyc(1'b1, phys(1, 2));
    check("press_c21_valid", key_valid, 1);
    check("press_value", key_value, 4'h8);
    check("press_held", key_held, 1);
    for (int i = 0; i < 5; i++) cyc(1'b1, phys(1, 2));
    check("press_frozen", col, 1);

    // Release with a glitch: only four consecutive idle samples release.
    cyc(1'b1, 4'hF); cyc(1'b1, 4'hF); cyc(1'b1, 4'hF);
    cyc(1'b1, 4'b1101);
    cyc(1'b1, 4'hF); cyc(1'b1, 4'hF); cyc(1'b1, 4'hF);
    check("release_not_yet", key_held, 1);
    cyc(1'b1, 4'hF);
    check("release_held", key_held, 0);
    check("release_col", col, 2);
    check("release_one_pulse", pulses, 1);

    // Bounce in col3 never debounces.
    wait_col(2'd3, 1'b0, 0, 0);
    pulses = 0;
    for (int i = 0; i < 40; i++) cyc(1'b1, ((i / 2) % 2 == 0) ? 4'hE : 4'hF);
    check("bounce_no_pulse", pulses, 0);
    check("bounce_left_col3", (col != 2'd3), 1);

    // Two rows low in col0 is no key.
    wait_col(2'd0, 1'b0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(1'b1, 4'b0011);
    check("multi_col", col, 1);
    check("multi_value", key_value, 4'h8);
    check("multi_no_pulse", pulses, 0);

    // Key C held, then async reset mid-cycle.
    wait_held(3, 3);
    check("c_value", key_value, 4'hC);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check("rst_drv", col_drv_n, 4'hF);
    #1 rst_n = 1'b1;

    // Enable drop while debouncing key 1 in col0.
    pulses = 0;
    cyc(1'b1, 4'hF);
    for (int i = 0; i < 17; i++) cyc(1'b1, phys(0, 0));
    cyc(1'b0, phys(0, 0));
    check("dis_drv", col_drv_n, 4'hF);
    check("dis_held", key_held, 0);
    for (int i = 0; i < 4; i++) cyc(1'b0, phys(0, 0));
    check("dis_no_pulse", pulses, 0);
    check("dis_col_kept", col, 0);

    // Random key activity, noise and occasional enable drops.
    hold_left = 0;
    key_on = 0; kc = 0; kr = 0;
    for (int n = 0; n < 3000; n++) begin
      if (hold_left == 0) begin
        key_on    = ($urandom_range(0, 2) != 0);
        kc        = $urandom_range(0, 3);
        kr        = $urandom_range(0, 3);
        hold_left = $urandom_range(30, 150);
      end else begin
        hold_left--;
      end
      en = ($urandom_range(0, 99) != 0);
      rv = key_on ? phys(kc, kr) : 4'hF;
      if ($urandom_range(0, 29) == 0) rv = 4'($urandom);
      cyc(en, rv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Column-scan sequencer for the 4x4 hex keypad. It drives the column select and waits for the row lines to settle, then samples the active-low rows. A press is debounced and reported once as a single-cycle event with its 4-bit hex code. Scanning is frozen while the key is held. The block sits between the keypad pins and the downstream consumer of key codes (display/entry logic), and replaces free-running column inputs with a controlled scan.

Parameters:
SETTLE_CYCLES, 16, cycles after any column change before rows are sampled (min 1)
DEBOUNCE_CNT, 4, consecutive identical samples required to accept a press or a release (min 2)
CNT_W, 8, width of the shared settle/debounce counter; must hold max(SETTLE_CYCLES, DEBOUNCE_CNT)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
enable  in  1  scan enable; low holds the block in IDLE
row  in  4  keypad rows, active-low; row[3]=row0 (top) .. row[0]=row3 (bottom); assumed pre-synchronised
col  out  2  current column index 0..3
col_drv_n  out  4  one-hot-low column drive; col_drv_n[c]=0 for col=c; 4'b1111 in IDLE
key_value  out  4  hex code of the last accepted key; holds until the next accept
key_valid  out  1  one-cycle pulse when a press is accepted
key_held  out  1  high from accept until the release is debounced

Behaviour:
- Reset (async assert, sync release): state=IDLE, col=0, col_drv_n=4'b1111, key_value=0, key_valid=0, key_held=0, counter=0.
- Key map, by (col, active row 0..3):
  - col0: 1, 4, 7, A
  - col1: 2, 5, 8, 0
  - col2: 3, 6, 9, B
  - col3: F, E, D, C
- Valid press pattern means exactly one row low: 0111, 1011, 1101, 1110. Any other non-1111 pattern (multi-row) is invalid and treated as no key.
- State machine:
  - IDLE: when enable=1, go to SETTLE with col unchanged and the counter cleared. Drive col_drv_n from col in every state except IDLE.
  - SETTLE: increment the counter. When the counter reaches SETTLE_CYCLES-1, go to SAMPLE.
  - SAMPLE: sample row once.
    - Valid pattern: latch the pattern, set the counter to 1, go to DEBOUNCE.
    - Otherwise: col<=col+1 (3 wraps to 0), clear the counter, go to SETTLE.
  - DEBOUNCE: sample every cycle.
    - Match with latched pattern: counter++. When the counter reaches DEBOUNCE_CNT, go to PRESSED, register key_value, pulse key_valid for 1 cycle (in the first PRESSED cycle), set key_held=1.
    - Mismatch: advance col, clear the counter, go to SETTLE, with no event.
  - PRESSED: col stays frozen.
    - row==4'b1111 increments the counter; any other value clears it.
    - When the counter reaches DEBOUNCE_CNT: key_held<=0, advance col, go to SETTLE.
    - A second key in the same column does not generate an event.
- Latency: with the key already stable when its column is selected, key_valid rises SETTLE_CYCLES+DEBOUNCE_CNT+1 cycles after col changes to that column (19+1=20... exact: 16 settle + 1 sample + 3 debounce = key_valid in cycle 21 counted from the column change as cycle 1).
- enable falling in any state: go to IDLE on the next edge, with col_drv_n=1111 and key_held=0. No key_valid is issued. col is retained and key_value is retained.
- enable rising: go to SETTLE on the current col.
- Reset mid-operation: immediate return to reset values. Any partial debounce is discarded.
- key_valid never asserts on two consecutive cycles. Exactly one pulse is issued per press/release cycle.

Decomposition:
- keypad_pkg holds:
  - state encodings IDLE/SETTLE/SAMPLE/DEBOUNCE/PRESSED
  - ROW_NONE=4'b1111 and the four valid row patterns
  - function key_code(col,row) implementing the key map
  - function col_onehot_n(col)
- One natural sub-module: scan_counter, a clearable/incrementing CNT_W counter with a terminal-compare output, shared by SETTLE, DEBOUNCE and PRESSED.

Test Plan:
- No keys, enable=1, defaults: col cycles 0,1,2,3,0 every 17 cycles; col_drv_n tracks col (e.g. col=2 gives 1011); key_valid is never 1.
- Hold row=1101 while col=1 stays stable: key_valid pulses once with key_value=4'h8 in the 21st cycle after col became 1; key_held=1; col stays 1 until release.
- Release test: after the press above, row=1111 for 3 cycles then 1101 then 1111 for 4 cycles → key_held falls only after the 4 consecutive 1111 samples; col then advances to 2; no second key_valid.
- Bounce: in col3, row alternates 1110/1111 every 2 cycles → no key_valid; scanning continues to col0.
- Multi-key: row=0011 in col0 → treated as no key; col advances; key_value keeps its previous value.
- Async reset while in PRESSED (key C held), and enable=0 during DEBOUNCE: outputs return to reset values or IDLE immediately (col_drv_n=1111, key_held=0), with no key_valid pulse.
